// File: rtl/aes_serial_ctrl.sv
// rtl/aes_serial_ctrl.sv - serial-link sequencer for the AES Cipher/InvCipher cores
// Optional DONE-state watchdog with sticky err_tmo: define AES_CTRL_TIMEOUT_EN.
module aes_serial_ctrl #(
  parameter int KEY_BITS = 256,
  parameter int WAIT_CYC = 47,
  parameter int TMO_CYC  = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_mode,
  input  logic [127:0]        in_data,
  input  logic [KEY_BITS-1:0] in_key,
  output logic                cs_enc_n,
  output logic                cs_dec_n,
  output logic                mosi,
  input  logic                miso,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic                out_mode,
  output logic                busy
`ifdef AES_CTRL_TIMEOUT_EN
  ,
  output logic                err_tmo
`endif
);

  localparam int MAX1 = (KEY_BITS > 128) ? KEY_BITS : 128;
  localparam int MAX2 = (WAIT_CYC > MAX1) ? WAIT_CYC : MAX1;
  localparam int MAXV = (TMO_CYC > MAX2) ? TMO_CYC : MAX2;
  localparam int CW   = $clog2(MAXV + 1);
  localparam int KW   = $clog2(KEY_BITS);

  typedef enum logic [2:0] {
    IDLE, LOAD_DATA, LOAD_KEY, WAIT, CAPTURE, DONE
  } state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         bit_cnt, cnt_nxt;
  logic [127:0]          data_reg;
  logic [KEY_BITS-1:0]   key_reg;
  logic                  mode_reg;
  logic                  ready_en;
  logic                  accept;
  logic                  tmo_fire;
  logic                  link_active;

  // bit_cnt doubles as the DONE-state watchdog counter, so no extra register is needed
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    accept    = 1'b0;
    tmo_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept    = 1'b1;
          state_nxt = LOAD_DATA;
          cnt_nxt   = '0;
        end
      end
      LOAD_DATA: begin
        if (bit_cnt == CW'(127)) begin
          state_nxt = LOAD_KEY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = bit_cnt + 1'b1;
        end
      end
      LOAD_KEY: begin
        if (bit_cnt == CW'(KEY_BITS - 1)) begin
          state_nxt = WAIT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = bit_cnt + 1'b1;
        end
      end
      WAIT: begin
        if (bit_cnt == CW'(WAIT_CYC - 1)) begin
          state_nxt = CAPTURE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = bit_cnt + 1'b1;
        end
      end
      CAPTURE: begin
        if (bit_cnt == CW'(127)) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = bit_cnt + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
`ifdef AES_CTRL_TIMEOUT_EN
        else if (bit_cnt == CW'(TMO_CYC - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          tmo_fire  = 1'b1;
        end else begin
          cnt_nxt = bit_cnt + 1'b1;
        end
`endif
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      data_reg <= '0;
      key_reg  <= '0;
      mode_reg <= 1'b0;
      ready_en <= 1'b0;
      out_data <= '0;
      out_mode <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= cnt_nxt;
      ready_en <= 1'b1;
      if (accept) begin
        data_reg <= in_data;
        key_reg  <= in_key;
        mode_reg <= in_mode;
      end
      if (state == CAPTURE) begin
        out_data[bit_cnt[6:0]] <= miso;
      end
      if (state == CAPTURE && state_nxt == DONE) begin
        out_mode <= mode_reg;
      end
    end
  end

`ifdef AES_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_tmo <= 1'b0;
    end else if (accept) begin
      err_tmo <= 1'b0;
    end else if (tmo_fire) begin
      err_tmo <= 1'b1;
    end
  end
`endif

  // chip selects decode from state so they follow the acceptance and last-capture edges exactly
  assign link_active = (state == LOAD_DATA) || (state == LOAD_KEY) ||
                       (state == WAIT) || (state == CAPTURE);
  assign cs_enc_n    = !(link_active && !mode_reg);
  assign cs_dec_n    = !(link_active && mode_reg);
  assign in_ready    = ready_en && (state == IDLE);
  assign out_valid   = (state == DONE);
  assign busy        = (state != IDLE);

  always_comb begin
    mosi = 1'b0;
    case (state)
      LOAD_DATA: mosi = data_reg[bit_cnt[6:0]];
      LOAD_KEY:  mosi = key_reg[bit_cnt[KW-1:0]];
      default:   mosi = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_aes_serial_ctrl.sv
// tb/tb_aes_serial_ctrl.sv - randomized self-checking bench for aes_serial_ctrl
// Stand-in core is an XOR involution of data with both key halves; AES_CTRL_TIMEOUT_EN adds err_tmo.
module tb_aes_serial_ctrl;

  localparam int KB  = 256;
  localparam int WC  = 47;
`ifdef AES_CTRL_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif
  localparam int LAT = 128 + KB + WC + 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_mode = 1'b0;
  logic [127:0]  in_data = '0;
  logic [KB-1:0] in_key = '0;
  logic          cs_enc_n, cs_dec_n, mosi;
  logic          miso = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [127:0]  out_data;
  logic          out_mode;
  logic          busy;
`ifdef AES_CTRL_TIMEOUT_EN
  logic          err_tmo;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aes_serial_ctrl #(.KEY_BITS(KB), .WAIT_CYC(WC), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_data(in_data), .in_key(in_key),
    .cs_enc_n(cs_enc_n), .cs_dec_n(cs_dec_n), .mosi(mosi), .miso(miso),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mode(out_mode), .busy(busy)
`ifdef AES_CTRL_TIMEOUT_EN
    , .err_tmo(err_tmo)
`endif
  );

  function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [KB-1:0] k);
    return d ^ k[127:0] ^ k[255:128];
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Serial core model: reconstructs the job from mosi and plays the result back on miso.
  bit           pat_en = 1'b0;
  int           ccnt = 0;
  logic [127:0] rx_d = '0;
  logic [KB-1:0] rx_k = '0;
  logic [127:0] cres = '0;

  always @(posedge clk) begin
    if (cs_enc_n && cs_dec_n) begin
      ccnt = 0;
      miso <= 1'b0;
    end else begin
      if (ccnt < 128) rx_d[ccnt] = mosi;
      else if (ccnt < 128 + KB) rx_k[ccnt-128] = mosi;
      ccnt++;
      if (ccnt == 128 + KB) cres = pat_en ? {16{8'ha5}} : core_fn(rx_d, rx_k);
      miso <= (ccnt >= 128 + KB + WC && ccnt < LAT) ? cres[ccnt-(128+KB+WC)] : 1'b0;
    end
  end

  // Reference model: a job is described only by the number of edges since acceptance.
  bit           m_active = 0;
  bit           m_ready_ok = 0;
  int           m_k = 0;
  int           m_tmo = 0;
  bit           m_err = 0;
  logic [127:0] m_data = '0;
  logic [KB-1:0] m_key = '0;
  logic         m_mode = 0;
  logic [127:0] m_exp = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_ready_ok = 0; m_k = 0; m_tmo = 0; m_err = 0;
    end else begin
      if (m_active) begin
        if (m_k < LAT) m_k++;
        else if (out_ready) m_active = 0;
`ifdef AES_CTRL_TIMEOUT_EN
        else begin
          m_tmo++;
          if (m_tmo == TMO) begin m_active = 0; m_err = 1; end
        end
`endif
      end else if (m_ready_ok && in_valid) begin
        m_active = 1; m_k = 0; m_tmo = 0; m_err = 0;
        m_data = in_data; m_key = in_key; m_mode = in_mode;
        m_exp = pat_en ? {16{8'ha5}} : core_fn(in_data, in_key);
      end
      m_ready_ok = 1;
    end
  end

  always @(negedge clk) begin
    logic exp_mosi;
    logic link;
    link = m_active && (m_k < LAT);
    exp_mosi = 1'b0;
    if (m_active && m_k < 128) exp_mosi = m_data[m_k];
    else if (m_active && m_k < 128 + KB) exp_mosi = m_key[m_k-128];
    check("in_ready", in_ready, m_ready_ok && !m_active);
    check("busy", busy, m_active);
    check("cs_enc_n", cs_enc_n, !(link && !m_mode));
    check("cs_dec_n", cs_dec_n, !(link && m_mode));
    check("mosi", mosi, exp_mosi);
    check("out_valid", out_valid, m_active && m_k == LAT);
    if (m_active && m_k == LAT) begin
      check("out_data", out_data, m_exp);
      check("out_mode", out_mode, m_mode);
    end
`ifdef AES_CTRL_TIMEOUT_EN
    check("err_tmo", err_tmo, m_err);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [127:0] d, input logic [KB-1:0] k, input logic m,
                         input int hold, output logic [127:0] res, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin step(); n++; end
    check("in_ready_wait", in_ready, 1'b1);
    in_valid = 1'b1; in_data = d; in_key = k; in_mode = m;
    step();
    lat = 0;
    while (!out_valid && lat < LAT + 50) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_key = ~in_key;
      in_mode = 1'($urandom_range(0, 1));
      step();
      lat++;
    end
    check("latency", lat, LAT);
    res = out_data;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("ready_after_done", in_ready, 1'b1);
  endtask

  localparam logic [255:0] KEY0 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;

  initial begin
    logic [127:0] res;
    int lat;
    step(); step();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_cs_enc_n", cs_enc_n, 1'b1);
    check("rst_cs_dec_n", cs_dec_n, 1'b1);
    check("rst_out_data", out_data, '0);
    check("rst_out_mode", out_mode, 1'b0);
    rst_n = 1'b1;
    step();
    check("first_in_ready", in_ready, 1'b1);

    run_job(PT0, KEY0, 1'b0, 0, res, lat);
    check("enc_literal", res, 128'h10013223544576679889baabdccdfeef);
    run_job(128'h10013223544576679889baabdccdfeef, KEY0, 1'b1, 3, res, lat);
    check("dec_literal", res, PT0);
    check("dec_mode", out_mode, 1'b1);

    pat_en = 1'b1;
    run_job({$urandom, $urandom, $urandom, $urandom}, {8{$urandom}}, 1'b0, 200, res, lat);
    check("a5_literal", res, 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5);
    pat_en = 1'b0;

    in_valid = 1'b1; in_data = PT0; in_key = KEY0; in_mode = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 300; i++) step();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cs_enc_n", cs_enc_n, 1'b1);
    check("midrst_cs_dec_n", cs_dec_n, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    step(); step();
    rst_n = 1'b1;
    step();

    for (int j = 0; j < 4; j++) begin
      run_job({$urandom, $urandom, $urandom, $urandom}, {8{$urandom}},
              1'($urandom_range(0, 1)), $urandom_range(0, 6), res, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
